// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receiver.
// Optional build macro used by ps2_scancode_rx: PS2_PARITY_CHECK_EN.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT_CODE = 8'hE0;
    localparam logic [7:0] PS2_BRK_CODE = 8'hF0;

    typedef struct packed {
        logic       is_ext;
        logic       is_break;
        logic [7:0] code;
    } ps2_entry_t;

    typedef struct packed {
        ps2_state_e state;
        logic [2:0] bit_idx;
        logic       parity_bit;
    } ps2_dbg_t;

    // PS/2 frames use odd parity over the eight data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is dropped
// unless a pop happens in the same cycle.
module ps2_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB separates full (MSBs differ) from empty (MSBs equal).
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host frame receiver that folds E0/F0 prefixes into flags and
// queues decoded scancodes. Define PS2_PARITY_CHECK_EN to reject bad-parity frames.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       is_ext,
    output logic       is_break,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overflow,
    output ps2_dbg_t   dbg
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    // Handshake: an entry transfers on any cycle where valid && ready; the head
    // (code/is_ext/is_break) holds steady otherwise, and valid never drops without a pop.

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   prev_clk;
    logic                   curr_clk;
    logic                   data_s;
    logic                   fall;

    ps2_state_e state, state_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          par_bit, par_bit_n;
    logic [CW-1:0] to_cnt, to_cnt_n;
    logic          frame_good, frame_good_n;
    logic          frame_err_q, frame_err_n;
    logic          parity_ok;

    logic          ext_pend;
    logic          brk_pend;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic          overflow_q;
    ps2_entry_t    push_entry;
    ps2_entry_t    head;

    // Synchronisers reset to the idle-high bus level so release cannot fake an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            prev_clk  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            prev_clk  <= curr_clk;
        end
    end

    assign curr_clk = clk_sync[SYNC_STAGES-1];
    assign data_s   = data_sync[SYNC_STAGES-1];
    assign fall     = prev_clk && !curr_clk;

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = odd_parity_ok(shreg, par_bit);
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_idx     <= '0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            to_cnt      <= '0;
            frame_good  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state       <= state_n;
            bit_idx     <= bit_idx_n;
            shreg       <= shreg_n;
            par_bit     <= par_bit_n;
            to_cnt      <= to_cnt_n;
            frame_good  <= frame_good_n;
            frame_err_q <= frame_err_n;
        end
    end

    always_comb begin
        state_n      = state;
        bit_idx_n    = bit_idx;
        shreg_n      = shreg;
        par_bit_n    = par_bit;
        to_cnt_n     = '0;
        frame_good_n = 1'b0;
        frame_err_n  = 1'b0;

        if (state != ST_IDLE && !fall) to_cnt_n = to_cnt + CW'(1);

        case (state)
            ST_IDLE: begin
                if (fall && !data_s) begin
                    state_n   = ST_DATA;
                    bit_idx_n = '0;
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shreg_n   = {data_s, shreg[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    par_bit_n = data_s;
                    state_n   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    if (data_s && parity_ok) frame_good_n = 1'b1;
                    else                     frame_err_n  = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // A stalled device clock abandons the frame rather than hanging mid-byte.
        if (state != ST_IDLE && !fall && to_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state_n     = ST_IDLE;
            to_cnt_n    = '0;
            frame_err_n = 1'b1;
        end
    end

    // shreg is untouched until the next start bit, so it still holds the byte here.
    assign push = frame_good && (shreg != PS2_EXT_CODE) && (shreg != PS2_BRK_CODE);
    assign push_entry = '{is_ext: ext_pend, is_break: brk_pend, code: shreg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= push && fifo_full && !pop;
            if (frame_err_q) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end else if (frame_good) begin
                if (shreg == PS2_EXT_CODE) begin
                    ext_pend <= 1'b1;
                end else if (shreg == PS2_BRK_CODE) begin
                    brk_pend <= 1'b1;
                end else begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end
            end
        end
    end

    ps2_sync_fifo #(
        .WIDTH ($bits(ps2_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign valid     = !fifo_empty;
    assign pop       = valid && ready;
    assign code      = valid ? head.code     : 8'h00;
    assign is_ext    = valid ? head.is_ext   : 1'b0;
    assign is_break  = valid ? head.is_break : 1'b0;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;
    assign dbg       = '{state: state, bit_idx: bit_idx, parity_bit: par_bit};

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: drives PS/2 frames and checks decoded entries.
module tb_ps2_scancode_rx;
    import ps2_pkg::*;

    localparam int TO    = 200;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] code;
    logic       is_ext, is_break, valid, frame_err, overflow;
    ps2_dbg_t   dbg;

    int errors = 0;
    int checks = 0;
    int beats = 0;
    int err_cnt = 0;
    int ovf_cnt = 0;
    int beats0, err0;
    logic [9:0] exp_q[$];

    ps2_scancode_rx #(
        .SYNC_STAGES    (2),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .code      (code),
        .is_ext    (is_ext),
        .is_break  (is_break),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overflow  (overflow),
        .dbg       (dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic d);
        ps2_data = d;
        tick(5);
        ps2_clk = 1'b0;
        tick(10);
        ps2_clk = 1'b1;
        tick(5);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ par_flip);
        send_bit(stop_b);
        ps2_data = 1'b1;
        tick(12);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, 1'b1, 1'b0);
    endtask

    // Scoreboard: every accepted beat must match the oldest expected entry.
    always @(negedge clk) begin
        if (frame_err) err_cnt++;
        if (overflow)  ovf_cnt++;
        if (!rst && valid && ready) begin
            beats++;
            if (exp_q.size() == 0) check("unexpected_beat", 32'(exp_q.size()), 32'd1);
            else check("pop_entry", {22'd0, is_ext, is_break, code}, {22'd0, exp_q.pop_front()});
        end
    end

    initial begin
        tick(3);
        check("rst_valid",     valid,     0);
        check("rst_code",      code,      0);
        check("rst_ext_brk",   {is_ext, is_break}, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overflow",  overflow,  0);
        rst = 1'b0;
        tick(3);
        ready = 1'b1;

        beats0 = beats;
        exp_q.push_back({1'b0, 1'b0, 8'h1C});
        send_good(8'h1C);
        check("1c_beats", beats - beats0, 1);
        check("1c_no_err", err_cnt, 0);

        beats0 = beats;
        exp_q.push_back({1'b1, 1'b1, 8'h75});
        send_good(8'hE0);
        send_good(8'hF0);
        check("prefix_no_beat", beats - beats0, 0);
        send_good(8'h75);
        check("e0f0_75_beats", beats - beats0, 1);

        beats0 = beats;
        exp_q.push_back({1'b1, 1'b0, 8'h14});
        exp_q.push_back({1'b0, 1'b1, 8'h1C});
        send_good(8'hE0);
        send_good(8'h14);
        send_good(8'hF0);
        send_good(8'h1C);
        check("ext_brk_beats", beats - beats0, 2);

        beats0 = beats;
        err0 = err_cnt;
        send_good(8'hF0);
        send_frame(8'h33, 1'b0, 1'b0);
        check("stop0_err", err_cnt - err0, 1);
        check("stop0_no_beat", beats - beats0, 0);
        exp_q.push_back({1'b0, 1'b0, 8'h21});
        send_good(8'h21);
        check("flags_cleared_beats", beats - beats0, 1);

        beats0 = beats;
        err0 = err_cnt;
`ifdef PS2_PARITY_CHECK_EN
        send_frame(8'h44, 1'b1, 1'b1);
        check("badpar_err", err_cnt - err0, 1);
        check("badpar_beats", beats - beats0, 0);
`else
        exp_q.push_back({1'b0, 1'b0, 8'h44});
        send_frame(8'h44, 1'b1, 1'b1);
        check("badpar_err", err_cnt - err0, 0);
        check("badpar_beats", beats - beats0, 1);
`endif

        beats0 = beats;
        err0 = err_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        ps2_data = 1'b1;
        tick(TO + 20);
        check("timeout_err", err_cnt - err0, 1);
        exp_q.push_back({1'b0, 1'b0, 8'h2A});
        send_good(8'h2A);
        check("after_timeout_beats", beats - beats0, 1);
        check("after_timeout_err", err_cnt - err0, 1);

        ready = 1'b0;
        send_good(8'h5A);
        check("held_valid", valid, 1);
        check("held_code", code, 8'h5A);
        err0 = err_cnt;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        ps2_data = 1'b1;
        tick(3);
        check("midrst_outputs", {valid, is_ext, is_break, code, frame_err, overflow}, 0);
        rst = 1'b0;
        tick(3);
        check("midrst_no_err", err_cnt - err0, 0);
        check("midrst_valid", valid, 0);
        beats0 = beats;
        ready = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 8'h16});
        send_good(8'h16);
        check("after_rst_beats", beats - beats0, 1);

        ready = 1'b0;
        beats0 = beats;
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back({2'b00, 8'h30 + 8'(i)});
            send_good(8'h30 + 8'(i));
        end
        check("full_no_ovf", ovf_cnt, 0);
        check("full_head_stable", code, 8'h30);
        send_good(8'h38);
        check("ovf_once", ovf_cnt, 1);
        check("ovf_head_stable", code, 8'h30);
        ready = 1'b1;
        tick(DEPTH + 10);
        check("drain_beats", beats - beats0, DEPTH);
        check("drain_empty", valid, 0);
        check("exp_q_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
